// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_barrel_shifter: log2(WIDTH)-stage LSL/LSR/ASR/ROR shifter   |
// | with valid/ready flow control.              Revision: 1.0            |
// +----------------------------------------------------------------------+
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  generate
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_barrel_shifter: WIDTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic             valid_q [SHW];
  logic             valid_d [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic [SHW-1:0]   amt_d   [SHW];
  logic [1:0]       mode_q  [SHW];
  logic [1:0]       mode_d  [SHW];
  logic             sign_q  [SHW];
  logic             sign_d  [SHW];

  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_amt   [SHW];
  logic [1:0]       src_mode  [SHW];
  logic             src_sign  [SHW];

  logic stall;

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic             sgn,
    input logic [1:0]       mode,
    input int               n
  );
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> n) : '0;
    case (mode)
      MODE_LSL: stage_shift = d << n;
      MODE_LSR: stage_shift = d >> n;
      MODE_ASR: stage_shift = (d >> n) | fill;
      MODE_ROR: stage_shift = (d >> n) | (d << (WIDTH - n));
      default:  stage_shift = d;
    endcase
  endfunction

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Stage 0 is fed from the ports; every later stage from its predecessor.
  // The sign bit is captured once so ASR fills with the operand's original MSB.
  generate
    for (genvar k = 0; k < SHW; k++) begin : g_src
      if (k == 0) begin : g_first
        assign src_valid[k] = in_valid;
        assign src_data[k]  = in_data;
        assign src_amt[k]   = in_amt;
        assign src_mode[k]  = in_mode;
        assign src_sign[k]  = in_data[WIDTH-1];
      end else begin : g_next
        assign src_valid[k] = valid_q[k-1];
        assign src_data[k]  = data_q[k-1];
        assign src_amt[k]   = amt_q[k-1];
        assign src_mode[k]  = mode_q[k-1];
        assign src_sign[k]  = sign_q[k-1];
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      amt_d[k]   = amt_q[k];
      mode_d[k]  = mode_q[k];
      sign_d[k]  = sign_q[k];
      if (!stall) begin
        valid_d[k] = src_valid[k];
        amt_d[k]   = src_amt[k];
        mode_d[k]  = src_mode[k];
        sign_d[k]  = src_sign[k];
        data_d[k]  = src_amt[k][k] ? stage_shift(src_data[k], src_sign[k], src_mode[k], 1 << k)
                                   : src_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        sign_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        amt_q[k]   <= amt_d[k];
        mode_q[k]  <= mode_d[k];
        sign_q[k]  <= sign_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_barrel_shifter: scoreboard bench for WIDTH=8 and 32.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic [2:0] ia8;
  logic [1:0] im8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic [4:0]  ia32;
  logic [1:0]  im32;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_amt(ia32), .in_mode(im32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit-by-bit reference: out[i] is taken directly from the source bit it maps to.
  function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                        input logic [1:0] m, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < w) ? d[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
        default: r[i] = d[(i+s) % w];
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  sb_t q8[$];
  sb_t q32[$];
  sb_t e8, e32;
  int  pops8 = 0;
  int  pops32 = 0;
  bit  lat_on = 1'b1;
  bit  stalled8 = 1'b0;
  logic [7:0] held8;

  bit bp_en = 1'b0;
  int bp_i  = 0;
  bit bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready8", {31'd0, ir8}, {31'd0, !(ov8 && !or8)});
      if (stalled8) begin
        check("stall_valid8", {31'd0, ov8}, 32'd1);
        check("stall_data8", {24'd0, od8}, {24'd0, held8});
      end
      stalled8 = ov8 && !or8;
      held8    = od8;
      if (ov8 && or8) begin
        pops8++;
        if (q8.size() == 0) check("extra8", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("data8", {24'd0, od8}, e8.exp);
          if (lat_on) check("lat8", cyc - e8.acc, 32'd2);
        end
      end
      if (iv8 && ir8) q8.push_back('{model({24'd0, id8}, int'(ia8), im8, 8), cyc + 1});

      check("in_ready32", {31'd0, ir32}, {31'd0, !(ov32 && !or32)});
      if (ov32 && or32) begin
        pops32++;
        if (q32.size() == 0) check("extra32", 32'd1, 32'd0);
        else begin
          e32 = q32.pop_front();
          check("data32", od32, e32.exp);
          if (lat_on) check("lat32", cyc - e32.acc, 32'd4);
        end
      end
      if (iv32 && ir32) q32.push_back('{model(id32, int'(ia32), im32, 32), cyc + 1});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        or8 = bp_pat[bp_i % 6];
        bp_i++;
      end
    end
  end

  task automatic send(input bit w32, input logic [31:0] d, input int a, input logic [1:0] m);
    int n;
    n = 0;
    if (w32) begin
      iv32 = 1'b1; id32 = d; ia32 = a[4:0]; im32 = m;
    end else begin
      iv8 = 1'b1; id8 = d[7:0]; ia8 = a[2:0]; im8 = m;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(w32 ? ir32 : ir8) && n < 100);
    check("send_accept", {31'd0, (w32 ? ir32 : ir8)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit w32);
    int n;
    n = 0;
    while ((w32 ? q32.size() : q8.size()) != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", w32 ? q32.size() : q8.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  bit pat [9];
  bit ovs [9];
  int p0;

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; or8 = 1'b1;
    iv32 = 1'b0; id32 = '0; ia32 = '0; im32 = '0; or32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid8", {31'd0, ov8}, 32'd0);
    check("rst_data8", {24'd0, od8}, 32'd0);
    check("rst_ready8", {31'd0, ir8}, 32'd1);
    check("rst_valid32", {31'd0, ov32}, 32'd0);
    check("rst_data32", od32, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mode sweep, back-to-back
    for (int m = 0; m < 4; m++) send(1'b0, 32'h96, 3, m[1:0]);
    iv8 = 1'b0;
    drain(1'b0);

    // Amount edges
    for (int m = 0; m < 4; m++) send(1'b0, 32'h81, 0, m[1:0]);
    for (int m = 0; m < 4; m++) send(1'b0, 32'h81, 7, m[1:0]);
    iv8 = 1'b0;
    drain(1'b0);

    // Backpressure with random words
    lat_on = 1'b0;
    p0 = pops8;
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b0, $urandom, $urandom_range(0, 7), 2'($urandom_range(0, 3)));
    iv8 = 1'b0;
    drain(1'b0);
    bp_en = 1'b0;
    or8 = 1'b1;
    check("bp_count", pops8 - p0, 32'd10);
    repeat (2) @(posedge clk);
    #1;
    lat_on = 1'b1;

    // Bubbles, with unknown payload on idle slots
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      iv8 = pat[i];
      if (pat[i]) begin
        id8 = 8'($urandom); ia8 = 3'($urandom); im8 = 2'($urandom);
      end else begin
        id8 = 'x; ia8 = 'x; im8 = 'x;
      end
      @(negedge clk);
      ovs[i] = ov8;
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0;
    for (int i = 0; i < 3; i++) check("bubble_lead", {31'd0, ovs[i]}, 32'd0);
    for (int i = 0; i < 6; i++) check("bubble_pat", {31'd0, ovs[i+3]}, {31'd0, pat[i]});
    drain(1'b0);

    // Reset mid-operation with a full, stalled pipeline
    p0 = pops8;
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 32'h40 + i, i + 1, 2'b11);
    iv8 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid8", {31'd0, ov8}, 32'd0);
    check("midrst_data8", {24'd0, od8}, 32'd0);
    check("midrst_ready8", {31'd0, ir8}, 32'd1);
    q8.delete();
    q32.delete();
    stalled8 = 1'b0;
    #1 rst_n = 1'b1;
    or8 = 1'b1;
    send(1'b0, 32'hC3, 2, 2'b10);
    iv8 = 1'b0;
    drain(1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_pops", pops8 - p0, 32'd1);

    // Width 32 sweep
    for (int m = 0; m < 4; m++) send(1'b1, 32'h8000_0001, 31, m[1:0]);
    iv32 = 1'b0;
    drain(1'b1);
    check("pops32", pops32, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
